// File: rtl/jzjpcc_pkg.sv
// Shared definitions for the jzjpcc writeback slice.
// Load funct3 encodings used by the extraction logic.
package jzjpcc_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/jzjpcc_load_extract.sv
// Selects and extends the byte/half/word a load addressed.
// Reserved funct3 values pass the memory word through.
module jzjpcc_load_extract
    import jzjpcc_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = '0;
        unique case (offset)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
        endcase
    end

    // Halfword select ignores offset[0], so misaligned halves still map
    assign sel_half = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        unique case (1'b1)
            (funct3 == F3_LB):  data = {{24{sel_byte[7]}}, sel_byte};
            (funct3 == F3_LBU): data = {24'h0, sel_byte};
            (funct3 == F3_LH):  data = {{16{sel_half[15]}}, sel_half};
            (funct3 == F3_LHU): data = {16'h0, sel_half};
            (funct3 == F3_LW):  data = word;
            default:            data = word;
        endcase
    end

endmodule

// File: rtl/jzjpcc_writeback.sv
// Writeback stage: result select, register file with write-through
// reads, bypass outputs and the retired-instruction counter.
module jzjpcc_writeback
    import jzjpcc_pkg::*;
#(
    parameter bit CLEAR_REGS_ON_RESET = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_writeback,
    input  logic [4:0]  rdAddr_writeback,
    input  logic        rdWriteEnable_writeback,
    input  logic        rdSource_writeback,
    input  logic [31:0] memoryOut_writeback,
    input  logic [31:0] aluResult_writeback,
    input  logic [2:0]  funct3_writeback,
    input  logic [1:0]  byteOffset_writeback,
    input  logic [4:0]  rs1Addr,
    input  logic [4:0]  rs2Addr,
    output logic [31:0] rs1Data,
    output logic [31:0] rs2Data,
    output logic [4:0]  rdAddr_forward,
    output logic        rdWriteEnable_forward,
    output logic [31:0] rdData_forward,
    output logic [63:0] instret
);

    logic [31:0] load_data;
    logic [31:0] result;
    logic        wr_en;
    logic [31:0] regs [1:31];
    logic [63:0] instret_q;

    jzjpcc_load_extract u_extract (
        .word   (memoryOut_writeback),
        .funct3 (funct3_writeback),
        .offset (byteOffset_writeback),
        .data   (load_data)
    );

    assign result = rdSource_writeback ? load_data : aluResult_writeback;
    assign wr_en  = valid_writeback & rdWriteEnable_writeback &
                    (rdAddr_writeback != 5'd0) & ~reset;

    assign rdAddr_forward        = rdAddr_writeback;
    assign rdData_forward        = result;
    assign rdWriteEnable_forward = wr_en;

    always_ff @(posedge clock) begin
        if (reset) begin
            if (CLEAR_REGS_ON_RESET) begin
                for (int i = 1; i < 32; i++) regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rdAddr_writeback] <= result;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            instret_q <= '0;
        else if (valid_writeback)
            instret_q <= instret_q + 64'd1;
    end

    assign instret = instret_q;

    // Same-cycle write is visible to readers without waiting for the edge
    always_comb begin
        rs1Data = '0;
        if (rs1Addr != 5'd0)
            rs1Data = (wr_en && rdAddr_writeback == rs1Addr) ? result : regs[rs1Addr];
    end

    always_comb begin
        rs2Data = '0;
        if (rs2Addr != 5'd0)
            rs2Data = (wr_en && rdAddr_writeback == rs2Addr) ? result : regs[rs2Addr];
    end

endmodule

// File: doc/jzjpcc_writeback.md
JZJPCC_WRITEBACK -- requirements
Module: jzjpcc_writeback

Interface
REQ-001 SHALL have parameter: CLEAR_REGS_ON_RESET, 1, 1 = all x1..x31 zeroed on reset, 0 = register contents untouched by reset.
REQ-002 SHALL have port: clock  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high.
REQ-004 SHALL have port: valid_writeback  in  1  instruction present in writeback this cycle.
REQ-005 SHALL have port: rdAddr_writeback  in  5  destination register.
REQ-006 SHALL have port: rdWriteEnable_writeback  in  1  destination write request.
REQ-007 SHALL have port: rdSource_writeback  in  1  0 = aluResult_writeback, 1 = extracted load data.
REQ-008 SHALL have port: memoryOut_writeback  in  32  raw word read from memory.
REQ-009 SHALL have port: aluResult_writeback  in  32  ALU result.
REQ-010 SHALL have port: funct3_writeback  in  3  load width/sign select.
REQ-011 SHALL have port: byteOffset_writeback  in  2  address bits [1:0] of the load.
REQ-012 SHALL have ports: rs1Addr, rs2Addr  in  5 each  decode-stage read addresses.
REQ-013 SHALL have ports: rs1Data, rs2Data  out  32 each  read data.
REQ-014 SHALL have ports: rdAddr_forward out 5, rdWriteEnable_forward out 1, rdData_forward out 32  bypass to execute.
REQ-015 SHALL have port: instret  out  64  count of retired instructions.

Function
REQ-016 Effective write = valid_writeback & rdWriteEnable_writeback & (rdAddr_writeback != 0) & !reset.
REQ-017 Result = aluResult_writeback when rdSource_writeback=0, else load-extracted data per REQ-018..020.
REQ-018 Load extraction: 000 LB = sign-extend byte[offset]; 100 LBU = zero-extend byte[offset]; 001 LH = sign-extend half[offset[1]]; 101 LHU = zero-extend half[offset[1]]; 010 LW = full word.
REQ-019 Halfword loads SHALL ignore offset[0] (misaligned offsets 01/11 select halves 0/1); LW SHALL ignore offset entirely.
REQ-020 Reserved funct3 (011, 110, 111) SHALL pass memoryOut_writeback through unmodified.
REQ-021 Register file: 31 x 32-bit registers, written on the rising edge when the effective write holds.
REQ-022 Reads combinational; address 0 SHALL return 0x00000000 regardless of any write.
REQ-023 Write-through: a read of the register being written in the same cycle SHALL return the new Result (zero latency).
REQ-024 Both read ports are independent; rs1Addr == rs2Addr is legal and returns identical data.
REQ-025 Forward outputs combinational: rdAddr_forward = rdAddr_writeback, rdData_forward = Result, rdWriteEnable_forward = the effective write (low for x0, invalid or reset).
REQ-026 instret SHALL increment by 1 on every rising edge with valid_writeback=1 and reset=0, independent of rdWriteEnable; it SHALL wrap from 0xFFFF_FFFF_FFFF_FFFF to 0.

Reset
REQ-027 With reset high at an edge: instret <= 0; if CLEAR_REGS_ON_RESET=1, x1..x31 <= 0.
REQ-028 Any write or retirement presented in the same cycle as reset SHALL be dropped.
REQ-029 Combinational outputs SHALL continue to follow inputs during reset, except rdWriteEnable_forward = 0.

Structure
REQ-030 Shared package jzjpcc_pkg SHALL hold the load funct3 encodings (LB, LH, LW, LBU, LHU) as named constants.
REQ-031 Load extraction SHALL be a separate combinational sub-module jzjpcc_load_extract (inputs: word, funct3, offset; output: 32-bit data).
REQ-032 Register file and instret counter SHALL reside in jzjpcc_writeback itself.

Verification
REQ-033 memoryOut=0x8899AABB, rdSource=1, funct3=000, offset=2, rd=5, valid=1 -> x5 = 0xFFFFFF99; with funct3=100 -> x5 = 0x00000099.
REQ-034 Same word, funct3=001, offset=3 -> 0xFFFF8899; funct3=101, offset=0 -> 0x0000AABB; funct3=110 -> 0x8899AABB.
REQ-035 Write aluResult=0x12345678 to x0 with rs1Addr=0 -> rs1Data=0, rdWriteEnable_forward=0; register file unchanged.
REQ-036 Write 0xDEADBEEF to x7 with rs1Addr=rs2Addr=7 same cycle -> both read 0xDEADBEEF before the edge and after it.
REQ-037 Preload instret near wrap via 2^64-1 valid cycles (or forced start state) -> next valid cycle yields 0; valid=0 cycles leave count unchanged.
REQ-038 Assert reset while writing x3=0x1 and valid=1 -> x3 = 0, instret = 0 after the edge (CLEAR_REGS_ON_RESET=1); with parameter 0, x3 retains its prior value.
